// File: rtl/rob_freelist_if.sv
// Rename/retire interface between the front end and the ROB/free-list back end.
// The front end drives allocation requests and completion broadcasts (master).
// The back end returns grants, stall and commit information (slave).
interface rob_freelist_if #(
    parameter int unsigned ROB_DEPTH = 16,
    parameter int unsigned PRF_NUM   = 32,
    parameter int unsigned ARF_NUM   = 8
);
    localparam int unsigned RW = $clog2(ROB_DEPTH);
    localparam int unsigned TW = $clog2(PRF_NUM);
    localparam int unsigned AW = $clog2(ARF_NUM);

    logic          alloc_valid;
    logic [AW-1:0] alloc_Rw;
    logic [TW-1:0] alloc_tag_Rw_old;
    logic [TW-1:0] tag_PRF_out;
    logic [RW-1:0] tag_ROB_out;
    logic          freeze_front;
    logic          valid_Result_add;
    logic [RW-1:0] tag_ROB_add;
    logic          valid_Result_mul;
    logic [RW-1:0] tag_ROB_mul;
    logic          commit_valid;
    logic [AW-1:0] commit_Rw;
    logic [TW-1:0] commit_tag_PRF;
    logic [TW-1:0] ARF_tag [ARF_NUM];

    modport master (
        output alloc_valid, alloc_Rw, alloc_tag_Rw_old,
        output valid_Result_add, tag_ROB_add, valid_Result_mul, tag_ROB_mul,
        input  tag_PRF_out, tag_ROB_out, freeze_front,
        input  commit_valid, commit_Rw, commit_tag_PRF, ARF_tag
    );

    modport slave (
        input  alloc_valid, alloc_Rw, alloc_tag_Rw_old,
        input  valid_Result_add, tag_ROB_add, valid_Result_mul, tag_ROB_mul,
        output tag_PRF_out, tag_ROB_out, freeze_front,
        output commit_valid, commit_Rw, commit_tag_PRF, ARF_tag
    );
endinterface

// File: rtl/rob_freelist.sv
// Reorder buffer plus PRF free list: grants PRF/ROB tags to renamed
// instructions, tracks completion, retires in order and recycles old tags.
module rob_freelist #(
    parameter int unsigned ROB_DEPTH = 16,
    parameter int unsigned PRF_NUM   = 32,
    parameter int unsigned ARF_NUM   = 8
) (
    input  logic           clk,
    input  logic           rst,
    rob_freelist_if.slave  bus
);
    localparam int unsigned RW  = $clog2(ROB_DEPTH);
    localparam int unsigned TW  = $clog2(PRF_NUM);
    localparam int unsigned AW  = $clog2(ARF_NUM);
    localparam int unsigned CAP = PRF_NUM - ARF_NUM;
    localparam int unsigned FW  = $clog2(CAP);
    localparam int unsigned CW  = $clog2(CAP + 1);
    localparam int unsigned QW  = $clog2(ROB_DEPTH + 1);
    localparam int unsigned OW  = QW + 1;

    // ROB storage
    logic [AW-1:0]        rw_q   [ROB_DEPTH];
    logic [AW-1:0]        rw_d   [ROB_DEPTH];
    logic [TW-1:0]        tag_q  [ROB_DEPTH];
    logic [TW-1:0]        tag_d  [ROB_DEPTH];
    logic [TW-1:0]        old_q  [ROB_DEPTH];
    logic [TW-1:0]        old_d  [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] done_q, done_d;
    logic [RW-1:0]        head_q, head_d, tail_q, tail_d;
    logic [QW-1:0]        rob_cnt_q, rob_cnt_d;

    // free list storage
    logic [TW-1:0]        fl_q   [CAP];
    logic [TW-1:0]        fl_d   [CAP];
    logic [FW-1:0]        fl_head_q, fl_head_d, fl_tail_q, fl_tail_d;
    logic [CW-1:0]        fl_cnt_q, fl_cnt_d;

    // committed map and commit report
    logic [TW-1:0]        arf_q  [ARF_NUM];
    logic [TW-1:0]        arf_d  [ARF_NUM];
    logic                 cv_q, cv_d;
    logic [AW-1:0]        crw_q, crw_d;
    logic [TW-1:0]        cprf_q, cprf_d;

    logic                 freeze, do_alloc, do_commit;

    function automatic logic [RW-1:0] rob_inc(input logic [RW-1:0] p);
        return (p == RW'(ROB_DEPTH - 1)) ? '0 : p + RW'(1);
    endfunction

    function automatic logic [FW-1:0] fl_inc(input logic [FW-1:0] p);
        return (p == FW'(CAP - 1)) ? '0 : p + FW'(1);
    endfunction

    // A tag is live when its distance from head is below the occupancy.
    function automatic logic occupied(input logic [RW-1:0] t, input logic [RW-1:0] h,
                                      input logic [QW-1:0] n);
        logic [OW-1:0] off;
        if (t >= h) off = OW'(t) - OW'(h);
        else        off = OW'(t) + OW'(ROB_DEPTH) - OW'(h);
        return off < OW'(n);
    endfunction

    assign freeze    = (rob_cnt_q == QW'(ROB_DEPTH)) | (fl_cnt_q == '0);
    assign do_alloc  = bus.alloc_valid & ~freeze;
    assign do_commit = (rob_cnt_q != '0) & done_q[head_q];

    assign bus.tag_PRF_out    = fl_q[fl_head_q];
    assign bus.tag_ROB_out    = tail_q;
    assign bus.freeze_front   = freeze;
    assign bus.commit_valid   = cv_q;
    assign bus.commit_Rw      = crw_q;
    assign bus.commit_tag_PRF = cprf_q;
    assign bus.ARF_tag        = arf_q;

    // Next-state: completions, allocation at tail, retirement at head.
    always_comb begin
        rw_d      = rw_q;
        tag_d     = tag_q;
        old_d     = old_q;
        done_d    = done_q;
        head_d    = head_q;
        tail_d    = tail_q;
        rob_cnt_d = rob_cnt_q;
        fl_d      = fl_q;
        fl_head_d = fl_head_q;
        fl_tail_d = fl_tail_q;
        fl_cnt_d  = fl_cnt_q;
        arf_d     = arf_q;
        cv_d      = 1'b0;
        crw_d     = crw_q;
        cprf_d    = cprf_q;

        if (bus.valid_Result_add && occupied(bus.tag_ROB_add, head_q, rob_cnt_q))
            done_d[bus.tag_ROB_add] = 1'b1;
        if (bus.valid_Result_mul && occupied(bus.tag_ROB_mul, head_q, rob_cnt_q))
            done_d[bus.tag_ROB_mul] = 1'b1;

        if (do_alloc) begin
            rw_d[tail_q]   = bus.alloc_Rw;
            tag_d[tail_q]  = fl_q[fl_head_q];
            old_d[tail_q]  = bus.alloc_tag_Rw_old;
            done_d[tail_q] = 1'b0;
            tail_d         = rob_inc(tail_q);
            fl_head_d      = fl_inc(fl_head_q);
        end

        if (do_commit) begin
            arf_d[rw_q[head_q]] = tag_q[head_q];
            fl_d[fl_tail_q]     = old_q[head_q];
            fl_tail_d           = fl_inc(fl_tail_q);
            head_d              = rob_inc(head_q);
            cv_d                = 1'b1;
            crw_d               = rw_q[head_q];
            cprf_d              = tag_q[head_q];
        end

        unique case ({do_alloc, do_commit})
            2'b10: begin
                rob_cnt_d = rob_cnt_q + QW'(1);
                fl_cnt_d  = fl_cnt_q - CW'(1);
            end
            2'b01: begin
                rob_cnt_d = rob_cnt_q - QW'(1);
                fl_cnt_d  = fl_cnt_q + CW'(1);
            end
            default: ;
        endcase
    end

    // State registers; reset empties the ROB and refills the free list.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
                rw_q[i]  <= '0;
                tag_q[i] <= '0;
                old_q[i] <= '0;
            end
            done_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            rob_cnt_q <= '0;
            for (int unsigned i = 0; i < CAP; i++)
                fl_q[i] <= TW'(ARF_NUM + i);
            fl_head_q <= '0;
            fl_tail_q <= '0;
            fl_cnt_q  <= CW'(CAP);
            for (int unsigned i = 0; i < ARF_NUM; i++)
                arf_q[i] <= TW'(i);
            cv_q      <= 1'b0;
            crw_q     <= '0;
            cprf_q    <= '0;
        end else begin
            rw_q      <= rw_d;
            tag_q     <= tag_d;
            old_q     <= old_d;
            done_q    <= done_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            rob_cnt_q <= rob_cnt_d;
            fl_q      <= fl_d;
            fl_head_q <= fl_head_d;
            fl_tail_q <= fl_tail_d;
            fl_cnt_q  <= fl_cnt_d;
            arf_q     <= arf_d;
            cv_q      <= cv_d;
            crw_q     <= crw_d;
            cprf_q    <= cprf_d;
        end
    end
endmodule
